// File: rtl/kyber_pkg.sv
// Shared constants and state encoding for the Kyber rejection-sampling datapath.
package kyber_pkg;

    localparam int KYBER_Q       = 3329;
    localparam int KYBER_N       = 256;
    localparam int SHAKE128_RATE = 1344;
    localparam int COEFF_W       = 12;

    // One supplied block can hold up to four SHAKE128 squeezes.
    localparam int MAXBITS   = 4 * SHAKE128_RATE;
    localparam int MAX_BYTES = MAXBITS / 8;
    localparam int PTR_W     = 10;  // byte pointer, 0..MAX_BYTES
    localparam int LEN_W     = 14;  // in_len width in bits
    localparam int IDX_W     = 8;   // out_index width
    localparam int CNT_W     = 9;   // coefficient counter, reaches KYBER_N
    localparam int STAT_W    = 10;  // rejection statistics counter

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PARSE,
        EMIT1,
        EMIT2,
        STARVE,
        DONE
    } rej_state_t;

endpackage

// File: rtl/rej_parse_unit.sv
// Combinational group decoder: picks bytes byte_ptr..byte_ptr+2 out of the
// latched block, forms the two 12-bit candidates and compares them against Q.
module rej_parse_unit
    import kyber_pkg::*;
(
    input  logic [MAXBITS-1:0] blk,
    input  logic [PTR_W-1:0]   byte_ptr,
    output logic [COEFF_W-1:0] d1,
    output logic [COEFF_W-1:0] d2,
    output logic               acc1,
    output logic               acc2
);

    // Three zero pad bytes so byte_ptr+2 never leaves the array, even when
    // the pointer sits at the very end of a full block.
    logic [7:0] byte_arr [MAX_BYTES+3];
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_BYTES; gi++) begin : g_bytes
            assign byte_arr[gi] = blk[8*gi +: 8];
        end
        for (gi = MAX_BYTES; gi < MAX_BYTES + 3; gi++) begin : g_pad
            assign byte_arr[gi] = 8'h00;
        end
    endgenerate

    assign b0 = byte_arr[byte_ptr];
    assign b1 = byte_arr[byte_ptr + PTR_W'(1)];
    assign b2 = byte_arr[byte_ptr + PTR_W'(2)];

    // d1 = b0 + 256*(b1 & 0xF), d2 = (b1 >> 4) + 16*b2
    assign d1   = {b1[3:0], b0};
    assign d2   = {b2, b1[7:4]};
    assign acc1 = (d1 < COEFF_W'(KYBER_Q));
    assign acc2 = (d2 < COEFF_W'(KYBER_Q));

endmodule

// File: rtl/rej_uniform_sampler.sv
// Kyber SampleNTT rejection sampler: turns a squeezed SHAKE128 byte string
// into exactly KYBER_N coefficients below Q, streamed over valid/ready.
// Requests another block (need_more) when the current one runs dry.
// Optional build macro REJ_SAMPLER_STATS_EN adds rej_count, a saturating
// count of rejected candidates since the last start.
module rej_uniform_sampler
    import kyber_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [MAXBITS-1:0] in_bits,
    input  logic [LEN_W-1:0]   in_len,
    input  logic               in_valid,
    output logic               need_more,
    output logic [COEFF_W-1:0] out_coeff,
    output logic [IDX_W-1:0]   out_index,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
`ifdef REJ_SAMPLER_STATS_EN
    ,
    output logic [STAT_W-1:0]  rej_count
`endif
);

    rej_state_t         state_reg,     state_next;
    logic [PTR_W-1:0]   byte_ptr_reg,  byte_ptr_next;
    logic [CNT_W-1:0]   coeff_cnt_reg, coeff_cnt_next;
    logic [COEFF_W-1:0] d1_reg,        d1_next;
    logic [COEFF_W-1:0] d2_reg,        d2_next;
    logic               acc1_reg,      acc1_next;
    logic               acc2_reg,      acc2_next;

    logic [MAXBITS-1:0] blk_reg;
    logic [LEN_W-1:0]   len_reg;
    logic               load_blk;

    logic [COEFF_W-1:0] pu_d1;
    logic [COEFF_W-1:0] pu_d2;
    logic               pu_acc1;
    logic               pu_acc2;

    logic [LEN_W-1:0]   need_bits;
    logic               group_short;
    logic               last_coeff;

    rej_parse_unit u_parse (
        .blk      (blk_reg),
        .byte_ptr (byte_ptr_reg),
        .d1       (pu_d1),
        .d2       (pu_d2),
        .acc1     (pu_acc1),
        .acc2     (pu_acc2)
    );

    // A whole group needs byte_ptr+3 bytes; compared in bits so every bit of
    // in_len participates (in_len is always a byte multiple).
    assign need_bits   = {1'b0, byte_ptr_reg, 3'b000} + LEN_W'(24);
    assign group_short = (need_bits > len_reg);
    assign last_coeff  = (coeff_cnt_reg == CNT_W'(KYBER_N - 1));

    // Next-state and datapath update decisions.
    always_comb begin
        state_next     = state_reg;
        byte_ptr_next  = byte_ptr_reg;
        coeff_cnt_next = coeff_cnt_reg;
        d1_next        = d1_reg;
        d2_next        = d2_reg;
        acc1_next      = acc1_reg;
        acc2_next      = acc2_reg;
        load_blk       = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next     = LOAD;
                    coeff_cnt_next = '0;
                end
            end
            LOAD, STARVE: begin
                // Trailing bytes (<3) of a previous block are simply dropped.
                if (in_valid) begin
                    state_next    = PARSE;
                    load_blk      = 1'b1;
                    byte_ptr_next = '0;
                end
            end
            PARSE: begin
                if (group_short) begin
                    state_next = STARVE;
                end else begin
                    d1_next       = pu_d1;
                    d2_next       = pu_d2;
                    acc1_next     = pu_acc1;
                    acc2_next     = pu_acc2;
                    byte_ptr_next = byte_ptr_reg + PTR_W'(3);
                    if (pu_acc1)      state_next = EMIT1;
                    else if (pu_acc2) state_next = EMIT2;
                    else              state_next = PARSE;
                end
            end
            EMIT1: begin
                if (out_ready) begin
                    coeff_cnt_next = coeff_cnt_reg + CNT_W'(1);
                    if (last_coeff)    state_next = DONE;  // d2 is not needed
                    else if (acc2_reg) state_next = EMIT2;
                    else               state_next = PARSE;
                end
            end
            EMIT2: begin
                if (out_ready) begin
                    coeff_cnt_next = coeff_cnt_reg + CNT_W'(1);
                    state_next     = last_coeff ? DONE : PARSE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state, pointer, counter and candidate registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            byte_ptr_reg  <= '0;
            coeff_cnt_reg <= '0;
            d1_reg        <= '0;
            d2_reg        <= '0;
            acc1_reg      <= 1'b0;
            acc2_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            byte_ptr_reg  <= byte_ptr_next;
            coeff_cnt_reg <= coeff_cnt_next;
            d1_reg        <= d1_next;
            d2_reg        <= d2_next;
            acc1_reg      <= acc1_next;
            acc2_reg      <= acc2_next;
        end
    end

    // Block capture; only read in PARSE after a load, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_blk) begin
            blk_reg <= in_bits;
            len_reg <= in_len;
        end
    end

    // Outputs are pure decodes of registered state, so out_ready never
    // reaches out_valid combinationally.
    assign out_valid = (state_reg == EMIT1) || (state_reg == EMIT2);
    assign out_coeff = (state_reg == EMIT2) ? d2_reg :
                       (state_reg == EMIT1) ? d1_reg : '0;
    assign out_index = coeff_cnt_reg[IDX_W-1:0];
    assign need_more = (state_reg == STARVE);
    assign done      = (state_reg == DONE);
    assign busy      = (state_reg != IDLE) && (state_reg != DONE);

`ifdef REJ_SAMPLER_STATS_EN
    logic [STAT_W-1:0] rej_count_reg;
    logic [1:0]        rej_add;
    logic [STAT_W:0]   rej_sum;
    logic              stats_clr;
    logic              stats_upd;

    assign rej_add   = {1'b0, ~pu_acc1} + {1'b0, ~pu_acc2};
    assign rej_sum   = {1'b0, rej_count_reg} + (STAT_W+1)'(rej_add);
    assign stats_clr = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign stats_upd = (state_reg == PARSE) && !group_short;

    // Saturating rejection counter; a d2 dropped at DONE was never rejected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rej_count_reg <= '0;
        end else if (stats_clr) begin
            rej_count_reg <= '0;
        end else if (stats_upd) begin
            rej_count_reg <= rej_sum[STAT_W] ? '1 : rej_sum[STAT_W-1:0];
        end
    end

    assign rej_count = rej_count_reg;
`endif

endmodule

// File: tb/tb_rej_uniform_sampler.sv
// Self-checking bench for rej_uniform_sampler: random byte blocks are parsed
// by a plain arithmetic reference model and compared against the stream.
module tb_rej_uniform_sampler;

    localparam int Q = 3329;
    localparam int N = 256;
    localparam int BUDGET = 6000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [5375:0] in_bits = '0;
    logic [13:0]   in_len = '0;
    logic          in_valid = 1'b0;
    logic          need_more;
    logic [11:0]   out_coeff;
    logic [7:0]    out_index;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          done;
`ifdef REJ_SAMPLER_STATS_EN
    logic [9:0]    rej_count;
`endif

    int n_checks = 0;
    int n_fail = 0;

    logic [5375:0] blk_mem [8];
    int            blk_bytes [8];
    int            exp_q [$];
    int            got_q [$];
    int            first_valid;

    rej_uniform_sampler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_bits   (in_bits),
        .in_len    (in_len),
        .in_valid  (in_valid),
        .need_more (need_more),
        .out_coeff (out_coeff),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
`ifdef REJ_SAMPLER_STATS_EN
        ,
        .rej_count (rej_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_blocks;
        for (int i = 0; i < 8; i++) begin
            blk_mem[i]   = '0;
            blk_bytes[i] = 0;
        end
    endtask

    task automatic set_byte(input int b, input int k, input int v);
        logic [7:0] v8;
        v8 = v[7:0];
        blk_mem[b][8*k +: 8] = v8;
    endtask

    task automatic rand_block(input int b, input int nbytes);
        blk_bytes[b] = nbytes;
        for (int k = 0; k < nbytes; k++) set_byte(b, k, int'($urandom_range(255)));
    endtask

    // Reference: walk whole 3-byte groups of each block in order, keep
    // candidates below Q until N are collected.
    task automatic build_model(input int nblk);
        int b0, b1, b2, c1, c2;
        exp_q.delete();
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i + 3 <= blk_bytes[b]; i += 3) begin
                b0 = int'(blk_mem[b][8*i +: 8]);
                b1 = int'(blk_mem[b][8*(i+1) +: 8]);
                b2 = int'(blk_mem[b][8*(i+2) +: 8]);
                c1 = b0 + 256 * (b1 % 16);
                c2 = b1 / 16 + 16 * b2;
                if (c1 < Q && exp_q.size() < N) exp_q.push_back(c1);
                if (c2 < Q && exp_q.size() < N) exp_q.push_back(c2);
            end
        end
    endtask

    task automatic do_reset;
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Start one polynomial, feed blocks on request, check every handshake.
    task automatic run_poly(input int nblk, input int ready_pct, input string tag);
        int  bi, got_n, held_c, held_i, e;
        bit  stall, finished;
        build_model(nblk);
        got_q.delete();
        first_valid = -1;
        start = 1'b1; tick; start = 1'b0;
        in_bits = blk_mem[0]; in_len = 14'(blk_bytes[0] * 8); in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        bi = 1; got_n = 0; stall = 0; finished = 0; held_c = 0; held_i = 0;
        for (int cyc = 0; cyc < BUDGET && !finished; cyc++) begin
            if (stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || int'(out_coeff) != held_c || int'(out_index) != held_i) begin
                    n_fail++;
                    $display("FAIL %s stall_hold: valid=%b coeff=%0d idx=%0d, required valid=1 coeff=%0d idx=%0d",
                             tag, out_valid, out_coeff, out_index, held_c, held_i);
                end
            end
            stall = 0;
            in_valid = 1'b0;
            if (done) finished = 1;
            else if (need_more) begin
                if (bi < nblk) begin
                    in_bits = blk_mem[bi]; in_len = 14'(blk_bytes[bi] * 8); in_valid = 1'b1;
                    bi++;
                end else finished = 1;
            end
            if (!finished) begin
                if (out_valid && first_valid < 0) first_valid = cyc;
                out_ready = (int'($urandom_range(99)) < ready_pct);
                if (out_valid) begin
                    if (out_ready) begin
                        e = (got_n < exp_q.size()) ? exp_q[got_n] : -1;
                        n_checks++;
                        if (int'(out_coeff) != e || int'(out_index) != (got_n % 256)) begin
                            n_fail++;
                            $display("FAIL %s coeff: idx=%0d coeff=%0d, required idx=%0d coeff=%0d",
                                     tag, out_index, out_coeff, got_n % 256, e);
                        end else begin
                            $display("tx %s idx=%0d coeff=%0d", tag, out_index, out_coeff);
                        end
                        got_q.push_back(int'(out_coeff));
                        got_n++;
                    end else begin
                        stall = 1; held_c = int'(out_coeff); held_i = int'(out_index);
                    end
                end
                tick;
            end
        end
        out_ready = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (!finished) begin
            n_fail++;
            $display("FAIL %s timeout: no done/need_more within %0d cycles", tag, BUDGET);
        end
        n_checks++;
        if (got_n != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s count: got %0d coeffs, required %0d", tag, got_n, exp_q.size());
        end
        n_checks++;
        if (done !== (exp_q.size() == N) || need_more !== (exp_q.size() < N)) begin
            n_fail++;
            $display("FAIL %s end_state: done=%b need_more=%b, required done=%b need_more=%b",
                     tag, done, need_more, exp_q.size() == N, exp_q.size() < N);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({out_valid, need_more, busy, done} !== 4'b0000 || out_coeff !== 12'd0 || out_index !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b need_more=%b busy=%b done=%b coeff=%0d idx=%0d, required all 0",
                     out_valid, need_more, busy, done, out_coeff, out_index);
        end
        do_reset();
        n_checks++;
        if ({out_valid, need_more, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_idle: valid=%b need_more=%b busy=%b done=%b, required 0000",
                     out_valid, need_more, busy, done);
        end
    endtask

    task automatic test_basic;
        do_reset(); clear_blocks();
        blk_bytes[0] = 3;
        set_byte(0, 0, 8'h01); set_byte(0, 1, 8'h02); set_byte(0, 2, 8'h03);
        run_poly(1, 100, "basic");
        n_checks++;
        if (got_q.size() != 2 || got_q[0] != 513 || got_q[1] != 48) begin
            n_fail++;
            $display("FAIL basic_values: got %0d coeffs, required 513,48", got_q.size());
        end
        n_checks++;
        if (first_valid != 1) begin
            n_fail++;
            $display("FAIL basic_latency: first valid at %0d, required 1", first_valid);
        end
        // start while starved must be ignored
        start = 1'b1; tick; start = 1'b0;
        n_checks++;
        if (need_more !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ignored: need_more=%b busy=%b, required 1 1", need_more, busy);
        end
    endtask

    task automatic test_boundary;
        do_reset(); clear_blocks();
        blk_bytes[0] = 6;
        set_byte(0, 0, 8'h01); set_byte(0, 1, 8'h0D); set_byte(0, 2, 8'h00);
        set_byte(0, 3, 8'h00); set_byte(0, 4, 8'h0D); set_byte(0, 5, 8'hD0);
        run_poly(1, 100, "boundary");
        n_checks++;
        if (got_q.size() != 3 || got_q[0] != 0 || got_q[1] != 3328 || got_q[2] != 3328) begin
            n_fail++;
            $display("FAIL boundary_values: got %0d coeffs, required 0,3328,3328 (3329 dropped)", got_q.size());
        end
    endtask

    task automatic test_reject_run;
        do_reset(); clear_blocks();
        blk_bytes[0] = 33;
        for (int k = 0; k < 30; k++) set_byte(0, k, 8'hFF);
        set_byte(0, 30, 8'h01); set_byte(0, 31, 8'h02); set_byte(0, 32, 8'h03);
        run_poly(1, 100, "reject_run");
        n_checks++;
        if (first_valid != 11 || got_q.size() != 2 || got_q[0] != 513) begin
            n_fail++;
            $display("FAIL reject_run: first valid at %0d with %0d coeffs, required 11 with 2 (513 first)",
                     first_valid, got_q.size());
        end
`ifdef REJ_SAMPLER_STATS_EN
        n_checks++;
        if (rej_count !== 10'd20) begin
            n_fail++;
            $display("FAIL rej_count: got %0d, required 20", rej_count);
        end
`endif
    endtask

    task automatic test_short_block;
        do_reset(); clear_blocks();
        blk_bytes[0] = 2;
        set_byte(0, 0, 8'h01); set_byte(0, 1, 8'h02);
        run_poly(1, 100, "short");
        n_checks++;
        if (first_valid != -1 || need_more !== 1'b1) begin
            n_fail++;
            $display("FAIL short_block: first valid at %0d need_more=%b, required none and 1", first_valid, need_more);
        end
    endtask

    task automatic test_random_full;
        do_reset(); clear_blocks();
        rand_block(0, 168); rand_block(1, 100); rand_block(2, 168);
        rand_block(3, 168); rand_block(4, 168);
        run_poly(5, 100, "random_full");
    endtask

    // Straight from DONE into a new polynomial with random back-pressure.
    task automatic test_back_to_back;
        clear_blocks();
        for (int b = 0; b < 4; b++) rand_block(b, 168);
        run_poly(4, 50, "backpressure");
    endtask

    task automatic test_reset_mid;
        do_reset(); clear_blocks();
        blk_bytes[0] = 3;
        set_byte(0, 0, 8'h01); set_byte(0, 1, 8'h02); set_byte(0, 2, 8'h03);
        start = 1'b1; tick; start = 1'b0;
        in_bits = blk_mem[0]; in_len = 14'd24; in_valid = 1'b1; tick; in_valid = 1'b0;
        for (int w = 0; w < 20 && !out_valid; w++) tick;
        n_checks++;
        if (out_valid !== 1'b1 || out_coeff !== 12'd513) begin
            n_fail++;
            $display("FAIL midrst_emit1: valid=%b coeff=%0d, required 1 513", out_valid, out_coeff);
        end
        out_ready = 1'b1; tick; out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_coeff !== 12'd48 || out_index !== 8'd1) begin
            n_fail++;
            $display("FAIL midrst_emit2: valid=%b coeff=%0d idx=%0d, required 1 48 1", out_valid, out_coeff, out_index);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_async: valid=%b busy=%b done=%b, required 000", out_valid, busy, done);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, busy, done, need_more} !== 4'b0000 || out_index !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_edge: valid=%b busy=%b done=%b need_more=%b idx=%0d, required all 0",
                     out_valid, busy, done, need_more, out_index);
        end
        rst_n = 1'b1;
        run_poly(1, 100, "after_reset");
        n_checks++;
        if (got_q.size() < 1 || got_q[0] != 513) begin
            n_fail++;
            $display("FAIL midrst_restart: %0d coeffs, required first coeff 513", got_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_reject_run();
        test_short_block();
        test_random_full();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
